compare_tally: RTL

Downstream stage of the 8-bit magnitude comparator. Accepts a window of WIN comparator results (operands A/B plus flags AEB/ASB/AGB) over a valid/ready input handshake. Over that window it counts each outcome, counts illegal flag patterns, and tracks the largest winning operand. When the window closes it presents a held report on a valid/ready output handshake.

---
 rtl/compare_tally.sv | 116 +++++++++++
 1 files changed

// File: rtl/compare_tally.sv
`default_nettype none
// ============================================================================
// Module   : compare_tally
// Brief    : Tallies a window of comparator results and reports the counts
//            and largest winning operand over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module compare_tally #(
  parameter int WIN = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       AEB,
  input  logic       ASB,
  input  logic       AGB,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] eq_cnt,
  output logic [7:0] lt_cnt,
  output logic [7:0] gt_cnt,
  output logic [7:0] err_cnt,
  output logic [7:0] max_win,
  output logic       busy
);

  localparam logic [7:0] c_last = 8'(WIN - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_REPORT = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_idx;
  logic [7:0] r_eq;
  logic [7:0] r_lt;
  logic [7:0] r_gt;
  logic [7:0] r_err;
  logic [7:0] r_max;
  logic       w_accept;
  logic       w_legal;
  logic       w_clear;
  logic [7:0] w_win;

  assign w_accept = in_valid && (r_state == S_ACCUM);
  assign w_clear  = (r_state == S_IDLE) && start;
  assign w_legal  = ({AEB, ASB, AGB} == 3'b100) ||
                    ({AEB, ASB, AGB} == 3'b010) ||
                    ({AEB, ASB, AGB} == 3'b001);
  // Only meaningful for legal samples, where ASB alone selects B.
  assign w_win    = ASB ? B : A;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_ACCUM;
      S_ACCUM:  if (w_accept && (r_idx == c_last)) w_next = S_REPORT;
      S_REPORT: if (out_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= 8'd0;
      r_eq  <= 8'd0;
      r_lt  <= 8'd0;
      r_gt  <= 8'd0;
      r_err <= 8'd0;
      r_max <= 8'd0;
    end else if (w_clear) begin
      r_idx <= 8'd0;
      r_eq  <= 8'd0;
      r_lt  <= 8'd0;
      r_gt  <= 8'd0;
      r_err <= 8'd0;
      r_max <= 8'd0;
    end else if (w_accept) begin
      r_idx <= r_idx + 8'd1;
      if (w_legal) begin
        if (AEB) r_eq <= r_eq + 8'd1;
        if (ASB) r_lt <= r_lt + 8'd1;
        if (AGB) r_gt <= r_gt + 8'd1;
        if (w_win > r_max) r_max <= w_win;
      end else begin
        r_err <= r_err + 8'd1;
      end
    end
  end

  assign in_ready  = (r_state == S_ACCUM);
  assign out_valid = (r_state == S_REPORT);
  assign busy      = (r_state != S_IDLE);
  assign eq_cnt    = r_eq;
  assign lt_cnt    = r_lt;
  assign gt_cnt    = r_gt;
  assign err_cnt   = r_err;
  assign max_win   = r_max;

endmodule
`default_nettype wire
